// File: rtl/ty_axis_pkg.sv
// Shared constants, helpers and types for the ty_axis_join stream adapter.
package ty_axis_pkg;

  localparam int TY_GVECT = 2;
  localparam int DATA_W   = 32 * TY_GVECT;

  // Occupancy counters need one extra bit so that "full" is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef enum logic [1:0] {SKID_EMPTY, SKID_ONE, SKID_FULL} skid_state_t;

endpackage

// File: rtl/ty_sync_fifo.sv
// Show-ahead synchronous FIFO with a registered occupancy count and a registered ready.
module ty_sync_fifo
  import ty_axis_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_empty
);

  localparam int CW = cnt_w(DEPTH);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_nxt;
  logic              r_ready;
  logic              w_push;
  logic              w_pop;

  assign o_empty = (r_count == '0);
  assign w_push  = i_valid & r_ready;
  assign w_pop   = i_pop & ~o_empty;

  // NOTE: assign a default before any branch so the combinational block never infers a latch.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CW'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      // Ready reflects the post-edge count, so a pop never frees a slot in its own cycle.
      r_ready <= (w_count_nxt != CW'(DEPTH));
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_ready = r_ready;
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/ty_axis_join.sv
// N-channel AXI-stream join with per-channel FIFOs and a 2-entry output skid buffer.
// Optional statistics counters are built when TY_AXIS_STATS_EN is defined.
module ty_axis_join
  import ty_axis_pkg::*;
#(
  parameter int NUM_IN     = 2,
  parameter int DATA_W     = ty_axis_pkg::DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          aclk,
  input  logic                          areset_n,
  input  logic [NUM_IN-1:0]             s_tvalid,
  input  logic [NUM_IN-1:0][DATA_W-1:0] s_tdata,
  output logic [NUM_IN-1:0]             s_tready,
  output logic                          k_ivalid,
  output logic [NUM_IN-1:0][DATA_W-1:0] k_idata,
  input  logic                          k_iready,
  input  logic                          k_ovalid,
  input  logic [DATA_W-1:0]             k_odata,
  output logic                          k_oready,
  output logic                          m_tvalid,
  output logic [DATA_W-1:0]             m_tdata,
  input  logic                          m_tready
`ifdef TY_AXIS_STATS_EN
  ,
  output logic [31:0]                   stat_join_beats,
  output logic [31:0]                   stat_out_beats,
  output logic [31:0]                   stat_stall_cycles
`endif
);

  logic [NUM_IN-1:0] w_empty;
  logic              w_join;
  logic              w_push;
  logic              w_pop;
  skid_state_t       r_state;
  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_spare;
  logic              r_oready;

  // All FIFOs pop together on a joined beat; no channel ever advances alone.
  assign k_ivalid = ~|w_empty;
  assign w_join   = k_ivalid & k_iready;

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_fifo
    ty_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk     (aclk),
      .rst_n   (areset_n),
      .i_valid (s_tvalid[gi]),
      .i_data  (s_tdata[gi]),
      .o_ready (s_tready[gi]),
      .i_pop   (w_join),
      .o_data  (k_idata[gi]),
      .o_empty (w_empty[gi])
    );
  end

  assign m_tvalid = (r_state != SKID_EMPTY);
  assign m_tdata  = r_head;
  assign k_oready = r_oready;
  assign w_push   = k_ovalid & r_oready;
  assign w_pop    = m_tvalid & m_tready;

  // k_oready is registered from the next state, breaking the m_tready -> k_oready path.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_state  <= SKID_EMPTY;
      r_head   <= '0;
      r_spare  <= '0;
      r_oready <= 1'b0;
    end else begin
      r_oready <= 1'b1;
      case (r_state)
        SKID_EMPTY: begin
          if (w_push) begin
            r_head  <= k_odata;
            r_state <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (w_push && w_pop) begin
            r_head <= k_odata;
          end else if (w_push) begin
            r_spare  <= k_odata;
            r_state  <= SKID_FULL;
            r_oready <= 1'b0;
          end else if (w_pop) begin
            r_state <= SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (w_pop) begin
            r_head  <= r_spare;
            r_state <= SKID_ONE;
          end else begin
            r_oready <= 1'b0;
          end
        end
        default: r_state <= SKID_EMPTY;
      endcase
    end
  end

`ifdef TY_AXIS_STATS_EN
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      stat_join_beats   <= '0;
      stat_out_beats    <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (w_join && stat_join_beats != '1)
        stat_join_beats <= stat_join_beats + 32'd1;
      if (w_pop && stat_out_beats != '1)
        stat_out_beats <= stat_out_beats + 32'd1;
      if (m_tvalid && !m_tready && stat_stall_cycles != '1)
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ty_axis_join.sv
// Self-checking bench for ty_axis_join: vector table with scoreboard plus corner-case sequences.
module tb_ty_axis_join;

  localparam int NUM_IN     = 2;
  localparam int DATA_W     = 64;
  localparam int FIFO_DEPTH = 4;

  typedef struct {
    logic [63:0] d0;
    logic [63:0] d1;
    logic [63:0] sum;
  } vec_t;

  logic                          aclk = 1'b0;
  logic                          areset_n;
  logic [NUM_IN-1:0]             s_tvalid;
  logic [NUM_IN-1:0][DATA_W-1:0] s_tdata;
  logic [NUM_IN-1:0]             s_tready;
  logic                          k_ivalid;
  logic [NUM_IN-1:0][DATA_W-1:0] k_idata;
  logic                          k_iready;
  logic                          k_ovalid;
  logic [DATA_W-1:0]             k_odata;
  logic                          k_oready;
  logic                          m_tvalid;
  logic [DATA_W-1:0]             m_tdata;
  logic                          m_tready;
`ifdef TY_AXIS_STATS_EN
  logic [31:0] stat_join_beats, stat_out_beats, stat_stall_cycles;
`endif

  // Bench-side kernel: either a loopback adder or fully hand-driven.
  logic              loop;
  logic              tb_iready;
  logic              tb_ovalid;
  logic [DATA_W-1:0] tb_odata;

  assign k_iready = loop ? k_oready : tb_iready;
  assign k_ovalid = loop ? (k_ivalid & k_oready) : tb_ovalid;
  assign k_odata  = loop ? (k_idata[0] + k_idata[1]) : tb_odata;

  always #5 aclk = ~aclk;

  ty_axis_join #(
    .NUM_IN     (NUM_IN),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .aclk     (aclk),
    .areset_n (areset_n),
    .s_tvalid (s_tvalid),
    .s_tdata  (s_tdata),
    .s_tready (s_tready),
    .k_ivalid (k_ivalid),
    .k_idata  (k_idata),
    .k_iready (k_iready),
    .k_ovalid (k_ovalid),
    .k_odata  (k_odata),
    .k_oready (k_oready),
    .m_tvalid (m_tvalid),
    .m_tdata  (m_tdata),
    .m_tready (m_tready)
`ifdef TY_AXIS_STATS_EN
    ,
    .stat_join_beats   (stat_join_beats),
    .stat_out_beats    (stat_out_beats),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  // Scoreboard: expectations queued at drive time, consumed when the DUT hands data over.
  logic [127:0] idata_q [$];
  logic [63:0]  out_q   [$];
  bit           mon_en = 1'b0;
  int           cyc = 0;
  int           first_join = -1;
  int           last_join  = -1;
  int           n_join     = 0;

  always @(negedge aclk) begin
    if (areset_n && mon_en) begin
      if (k_ivalid && k_iready) begin
        if (idata_q.size() == 0) fail("join_unexpected");
        else check("join_data", 128'(k_idata), idata_q.pop_front());
        if (first_join < 0) first_join = cyc;
        last_join = cyc;
        n_join++;
      end
      if (m_tvalid && m_tready) begin
        if (out_q.size() == 0) fail("out_unexpected");
        else check("out_data", 128'(m_tdata), 128'(out_q.pop_front()));
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_pair(input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] sum);
    bit ok = 1'b0;
    idata_q.push_back({d1, d0});
    out_q.push_back(sum);
    s_tvalid   = 2'b11;
    s_tdata[0] = d0;
    s_tdata[1] = d1;
    for (int t = 0; t < 100; t++) begin
      @(negedge aclk);
      if (s_tready == 2'b11) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("send_timeout");
    tick();
    s_tvalid = 2'b00;
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      if (idata_q.size() == 0 && out_q.size() == 0) break;
      @(negedge aclk);
    end
    check("drain_idata_q", 128'(idata_q.size()), 128'(0));
    check("drain_out_q", 128'(out_q.size()), 128'(0));
  endtask

  task automatic pulse_reset();
    #3 areset_n = 1'b0;
    #10 areset_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t        tbl [20];
  logic [63:0] bp [3];

  initial begin
    int acc, idx, n;
    bit a;

    areset_n  = 1'b0;
    s_tvalid  = '0;
    s_tdata   = '0;
    m_tready  = 1'b0;
    loop      = 1'b0;
    tb_iready = 1'b0;
    tb_ovalid = 1'b0;
    tb_odata  = '0;

    for (int i = 0; i < 16; i++) tbl[i] = '{64'(i), 64'(i), 64'(2 * i)};
    tbl[16] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0};
    tbl[17] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[18] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0};
    tbl[19] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 64'h2222_2222_2222_2211};
    bp[0] = 64'hD0D0_0000_0000_0001;
    bp[1] = 64'hD1D1_0000_0000_0002;
    bp[2] = 64'hD2D2_0000_0000_0003;

    // Reset values, then release between edges.
    #12;
    check("rst_s_tready", 128'(s_tready), 128'(0));
    check("rst_k_ivalid", 128'(k_ivalid), 128'(0));
    check("rst_k_oready", 128'(k_oready), 128'(0));
    check("rst_m_tvalid", 128'(m_tvalid), 128'(0));
    check("rst_k_idata", 128'(k_idata), 128'(0));
    check("rst_m_tdata", 128'(m_tdata), 128'(0));
    #10 areset_n = 1'b1;
    check("pre_edge_s_tready", 128'(s_tready), 128'(0));
    tick();
    check("post_edge_s_tready", 128'(s_tready), 128'(2'b11));
    check("post_edge_k_oready", 128'(k_oready), 128'(1));

    // Continuous stream through the loopback kernel.
    loop     = 1'b1;
    m_tready = 1'b1;
    mon_en   = 1'b1;
    for (int i = 0; i < 20; i++) send_pair(tbl[i].d0, tbl[i].d1, tbl[i].sum);
    drain();
    check("stream_join_count", 128'(n_join), 128'(20));
    check("stream_join_span", 128'(last_join - first_join), 128'(19));
    mon_en = 1'b0;

    // Skewed arrival: ch1 starts three cycles after ch0.
    loop      = 1'b0;
    tb_iready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      s_tvalid   = 2'b01;
      s_tdata[0] = 64'(100 + c);
      tick();
      check("skew_ready0", 128'(s_tready[0]), 128'(1));
      check("skew_no_join", 128'(k_ivalid), 128'(0));
    end
    s_tvalid   = 2'b11;
    s_tdata[0] = 64'd103;
    s_tdata[1] = 64'd200;
    tick();
    check("skew_first_valid", 128'(k_ivalid), 128'(1));
    check("skew_first_data", 128'(k_idata), {64'd200, 64'd100});
    for (int k = 1; k < 4; k++) begin
      s_tvalid   = 2'b10;
      s_tdata[1] = 64'(200 + k);
      tick();
      check("skew_join_data", 128'(k_idata), {64'(200 + k), 64'(100 + k)});
    end
    s_tvalid = 2'b00;
    tick();
    check("skew_drained", 128'(k_ivalid), 128'(0));

    // Channel overrun: ch0 holds valid for six cycles while ch1 is idle.
    acc      = 0;
    s_tvalid = 2'b01;
    for (int k = 0; k < 6; k++) begin
      s_tdata[0] = 64'(300 + acc);
      @(negedge aclk);
      a = s_tready[0];
      tick();
      if (a) begin
        acc++;
        if (acc == 4) check("ovr_ready_low", 128'(s_tready[0]), 128'(0));
      end
    end
    check("ovr_accept_count", 128'(acc), 128'(4));
    check("ovr_ready0", 128'(s_tready[0]), 128'(0));
    check("ovr_ready1", 128'(s_tready[1]), 128'(1));
    s_tvalid = 2'b10;
    for (int k = 0; k < 4; k++) begin
      s_tdata[1] = 64'(400 + k);
      tick();
      check("ovr_join_data", 128'(k_idata), {64'(400 + k), 64'(300 + k)});
      if (k == 1) check("ovr_ready_back", 128'(s_tready[0]), 128'(1));
    end
    s_tvalid = 2'b00;
    tick();
    check("ovr_drained", 128'(k_ivalid), 128'(0));

    // Output backpressure: sink stalls while the kernel offers three beats.
    tb_iready = 1'b0;
    m_tready  = 1'b0;
    idx       = 0;
    tb_ovalid = 1'b1;
    tb_odata  = bp[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      a = k_oready;
      if (idx > 0) begin
        check("bp_valid_held", 128'(m_tvalid), 128'(1));
        check("bp_data_held", 128'(m_tdata), 128'(bp[0]));
      end
      tick();
      if (a) begin
        idx++;
        tb_odata = bp[idx];
      end
    end
    check("bp_accept_count", 128'(idx), 128'(2));
    check("bp_oready_low", 128'(k_oready), 128'(0));
    m_tready = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge aclk);
      a = tb_ovalid & k_oready;
      if (m_tvalid) begin
        if (n < 3) check("bp_order", 128'(m_tdata), 128'(bp[n]));
        n++;
      end
      tick();
      if (a) begin
        idx++;
        if (idx < 3) tb_odata = bp[idx];
        else tb_ovalid = 1'b0;
      end
    end
    check("bp_out_count", 128'(n), 128'(3));

    // Mid-stream asynchronous reset with data held in both FIFOs and the skid buffer.
    m_tready   = 1'b0;
    s_tvalid   = 2'b11;
    s_tdata[0] = 64'h11;
    s_tdata[1] = 64'h22;
    tick();
    tb_ovalid = 1'b1;
    tb_odata  = 64'h77;
    tick();
    tb_ovalid = 1'b0;
    check("mid_pre_valid", 128'(k_ivalid & m_tvalid), 128'(1));
    #3 areset_n = 1'b0;
    #1;
    check("mid_s_tready", 128'(s_tready), 128'(0));
    check("mid_k_ivalid", 128'(k_ivalid), 128'(0));
    check("mid_k_oready", 128'(k_oready), 128'(0));
    check("mid_m_tvalid", 128'(m_tvalid), 128'(0));
    check("mid_k_idata", 128'(k_idata), 128'(0));
    check("mid_m_tdata", 128'(m_tdata), 128'(0));
    s_tvalid = 2'b00;
    #8 areset_n = 1'b1;
    tick();
    check("mid_rel_s_tready", 128'(s_tready), 128'(2'b11));
    check("mid_rel_k_oready", 128'(k_oready), 128'(1));
    check("mid_rel_no_join", 128'(k_ivalid), 128'(0));
    loop     = 1'b1;
    m_tready = 1'b1;
    mon_en   = 1'b1;
    send_pair(64'd5, 64'd6, 64'd11);
    drain();

    // Ten beats with exactly four output stall cycles.
    pulse_reset();
    m_tready = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send_pair(64'(i + 50), 64'(i), 64'(2 * i + 50));
      end
      begin
        int stalls = 0;
        for (int t = 0; t < 200 && stalls < 4; t++) begin
          @(negedge aclk);
          if (m_tvalid) stalls++;
        end
        @(posedge aclk);
        #1 m_tready = 1'b1;
      end
    join
    drain();
`ifdef TY_AXIS_STATS_EN
    check("stat_join_beats", 128'(stat_join_beats), 128'(10));
    check("stat_out_beats", 128'(stat_out_beats), 128'(10));
    check("stat_stall_cycles", 128'(stat_stall_cycles), 128'(4));
`endif
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ty_axis_join.md
# ty_axis_join

Parametrised N-channel AXI-stream front/back adapter for TyBEC-generated `main` kernels. It is the successor to the fixed 2-channel wrapper:
- Each input channel gets its own elastic FIFO, so per-channel `s_tready` no longer depends combinationally on the other channels' `tvalid`.
- The FIFO heads are joined into one lock-step beat for the kernel's single `ivalid`/`iready` handshake.
- The kernel output is decoupled from `m_tready` through a registered 2-entry skid buffer.

It sits between the SDx AXI-stream ports and the kernel, instantiated inside the top-level HDL wrapper.

## Interface
Parameters:
- `NUM_IN`, default 2: number of input stream channels, legal range 1..8.
- `DATA_W`, default 64: width of one packed vector beat; 32×`TY_GVECT`, maximum 512.
- `FIFO_DEPTH`, default 4: entries per input FIFO; power of two, at least 2.

Ports:
- `aclk`, in, 1: the single clock; all logic is on the rising edge.
- `areset_n`, in, 1: asynchronous active-low reset.
- `s_tvalid`, in, `NUM_IN`: per-channel input valid.
- `s_tdata`, in, `NUM_IN`×`DATA_W` (packed): per-channel input data.
- `s_tready`, out, `NUM_IN`: per-channel ready.
- `k_ivalid`, out, 1: joined beat valid, to the kernel `ivalid`.
- `k_idata`, out, `NUM_IN`×`DATA_W`: joined beat; channel *i* is on slice [*i*].
- `k_iready`, in, 1: kernel `iready`.
- `k_ovalid`, in, 1: kernel `ovalid`.
- `k_odata`, in, `DATA_W`: kernel output data.
- `k_oready`, out, 1: to the kernel `oready`.
- `m_tvalid`, out, 1: output stream valid.
- `m_tdata`, out, `DATA_W`: output stream data.
- `m_tready`, in, 1: sink ready.
- `stat_join_beats`, out, 32: joined beats consumed by the kernel. Present only when `TY_AXIS_STATS_EN` is defined.
- `stat_out_beats`, out, 32: beats delivered on the output stream. `TY_AXIS_STATS_EN` only.
- `stat_stall_cycles`, out, 32: output stall cycles. `TY_AXIS_STATS_EN` only.

## Operation
Input FIFOs:
- There is one synchronous FIFO per channel, with show-ahead read and a registered count of width clog2(`FIFO_DEPTH`)+1.
- `s_tready[i]` is the registered value of !full[i]. It is a function of FIFO *i* only and never of other channels.
- A push on channel *i* occurs when `s_tvalid[i]` & `s_tready[i]`.
- Push attempted while full: not accepted, because `s_tready` is low. A pop in the same cycle does not make room until the next cycle.
- Push and pop in the same cycle when not full: the count is unchanged and the data order is preserved.

Join:
- `k_ivalid` = AND over all channels of !empty[i].
- `k_idata` carries the FIFO heads.
- When `k_ivalid` & `k_iready`, all FIFOs pop together. No channel ever pops alone.
- A channel that runs ahead buffers up to `FIFO_DEPTH` beats, then backpressures only itself.

Output skid buffer (2 entries):
- The skid buffer has three states: EMPTY, ONE, FULL.
- `m_tvalid` = (state ≠ EMPTY). `m_tdata` is the head entry.
- `k_oready` is the registered value of (state ≠ FULL).
- State transitions:
  - EMPTY → ONE on a kernel push.
  - ONE → FULL on a push without a pop.
  - ONE → EMPTY on a pop without a push.
  - FULL → ONE on a pop.
  - A push and a pop in the same cycle hold the state.
- A kernel push is accepted only when `k_ovalid` & `k_oready`.

Reset:
- Asserting `areset_n` (low) immediately clears every FIFO pointer and count, and clears the skid state to EMPTY.
- Reset values: `s_tready` = 0, `k_ivalid` = 0, `k_oready` = 0, `m_tvalid` = 0, `k_idata`/`m_tdata` = 0, stats = 0.
- On the first edge after release, `s_tready` becomes all-ones and `k_oready` becomes 1.
- Data in flight at reset is discarded. No partial beat survives.

## Timing
- Input latency is 1 cycle: a beat accepted at edge *t* is visible on `k_idata`, with `k_ivalid` high if all channels are present, after edge *t*.
- Output latency is 1 cycle: kernel output accepted at edge *t* appears on `m_tvalid` after edge *t*.
- Throughput is 1 joined beat per cycle when all channels stream and `k_iready` = 1.
- Output throughput is 1 beat per cycle while `m_tready` = 1.
- There are no combinational paths from `s_tvalid` to `s_tready`, from `m_tready` to `k_oready`, or from `k_iready` to `s_tready`.
- AXI rule: once `m_tvalid` is asserted, `m_tvalid` and `m_tdata` stay stable until `m_tready`.

## Configuration
Macro `TY_AXIS_STATS_EN`.

When defined:
- The three 32-bit counters and their ports exist.
- `stat_join_beats` increments on each `k_ivalid` & `k_iready`.
- `stat_out_beats` increments on each `m_tvalid` & `m_tready`.
- `stat_stall_cycles` increments when `m_tvalid` & !`m_tready`.
- All three counters saturate at 0xFFFF_FFFF and clear on reset.

When undefined:
- The counters and ports are absent.
- Datapath behaviour is identical.

## Structure
- Package `ty_axis_pkg` holds:
  - the `TY_GVECT` default and `DATA_W` constant;
  - the clog2-based count-width function;
  - `typedef enum logic [1:0] {SKID_EMPTY, SKID_ONE, SKID_FULL}` for the skid state.
- Sub-module `ty_sync_fifo` (parameters `DATA_W`, `DEPTH`) is instantiated `NUM_IN` times in a generate loop.
- The skid buffer and the join logic stay in the top.

## Test plan
- **Reset then stream:** `NUM_IN`=2, both channels send 0..15 continuously, `k_iready`=1, with a loopback kernel returning ch0+ch1 → `k_idata` pairs (0,0)..(15,15) in order, `k_ivalid` high 16 consecutive cycles starting 1 cycle after the first beat.
- **Skewed arrival:** ch1 is delayed 3 cycles → ch0 buffers 3 beats, `s_tready[0]` stays 1 (`FIFO_DEPTH`=4), and the first joined beat appears 1 cycle after ch1's first beat.
- **Channel overrun:** ch1 is idle while ch0 sends 6 beats → ch0 accepts exactly 4, `s_tready[0]` is low from the cycle after the 4th accept, and `s_tready[1]` stays 1.
- **Output backpressure:** `m_tready`=0 for 5 cycles while the kernel presents 3 beats → exactly 2 accepted, `k_oready` low after the 2nd, `m_tdata` stable, and data order kept on release.
- **Mid-stream reset:** `areset_n` is pulled low asynchronously mid-burst → all outputs go to 0 within the same cycle, and after release the first output is the first post-reset beat.
- **`TY_AXIS_STATS_EN`:** 10 beats with 4 stall cycles → `stat_join_beats`=10, `stat_out_beats`=10, `stat_stall_cycles`=4.
